// File: rtl/dcache_2way_ctrl.sv
// 2-way set-associative, write-through, no-write-allocate data cache controller.
// Hides a multi-cycle backing memory behind cpu_ready; tracks LRU and read hit/miss statistics.
module dcache_2way_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 2,
    parameter int STAT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_rd_en,
    input  logic                         cpu_wr_en,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_ready,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [LINE_WORDS*DATA_W-1:0] mem_rdata,
    input  logic                         mem_ack,
    output logic [STAT_W-1:0]            hit_count,
    output logic [STAT_W-1:0]            miss_count
);

    localparam int OFF_B = $clog2(LINE_WORDS);
    localparam int SEL_W = (OFF_B > 0) ? OFF_B : 1;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - OFF_B - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t            state;
    logic [1:0]        valid [SETS];
    logic [SETS-1:0]   lru;
    logic [TAG_W-1:0]  tags  [2][SETS];
    logic [DATA_W-1:0] data  [2][SETS][LINE_WORDS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] line_addr;
    logic              hit0, hit1, hit, hit_way, victim;
    logic [DATA_W-1:0] hit_word, fill_word;

    assign idx       = cpu_addr[2+OFF_B +: IDX_W];
    assign tag       = cpu_addr[ADDR_W-1 -: TAG_W];
    assign line_addr = {cpu_addr[ADDR_W-1:2+OFF_B], {(2+OFF_B){1'b0}}};

    always_comb begin
        sel = '0;
        if (OFF_B > 0) sel = cpu_addr[2 +: SEL_W];
    end

    assign hit0      = valid[idx][0] && (tags[0][idx] == tag);
    assign hit1      = valid[idx][1] && (tags[1][idx] == tag);
    assign hit       = hit0 || hit1;
    assign hit_way   = ~hit0;
    assign victim    = !valid[idx][0] ? 1'b0 : (!valid[idx][1] ? 1'b1 : lru[idx]);
    assign hit_word  = data[hit_way][idx][sel];
    assign fill_word = mem_rdata[sel*DATA_W +: DATA_W];

    // Outputs decode state and inputs directly; forced to their reset values while rst is low.
    always_comb begin
        cpu_ready = 1'b1;
        cpu_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (cpu_wr_en) begin
                        cpu_ready = 1'b0;
                    end else if (cpu_rd_en) begin
                        if (hit) cpu_rdata = hit_word;
                        else     cpu_ready = 1'b0;
                    end
                end
                FILL: begin
                    mem_req   = 1'b1;
                    mem_addr  = line_addr;
                    cpu_ready = mem_ack;
                    if (mem_ack) cpu_rdata = fill_word;
                end
                WRITE: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                    cpu_ready = mem_ack;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            for (int unsigned s = 0; s < SETS; s++) valid[s] <= '0;
            lru        <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_wr_en) begin
                        state <= WRITE;
                    end else if (cpu_rd_en) begin
                        if (hit) begin
                            lru[idx] <= ~hit_way;
                            if (hit_count != '1) hit_count <= hit_count + STAT_W'(1);
                        end else begin
                            state <= FILL;
                            if (miss_count != '1) miss_count <= miss_count + STAT_W'(1);
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        valid[idx][victim] <= 1'b1;
                        lru[idx]           <= ~victim;
                        state              <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        if (hit) lru[idx] <= ~hit_way;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; they are qualified by valid.
    always_ff @(posedge clk) begin
        if (state == FILL && mem_ack) begin
            tags[victim][idx] <= tag;
            for (int unsigned w = 0; w < LINE_WORDS; w++)
                data[victim][idx][w] <= mem_rdata[w*DATA_W +: DATA_W];
        end else if (state == WRITE && mem_ack && hit) begin
            data[hit_way][idx][sel] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_dcache_2way_ctrl.sv
// Self-checking bench for dcache_2way_ctrl: directed plan steps followed by random traffic,
// checked against a recency-list cache model and a flat backing-memory model.
module tb_dcache_2way_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd_en, cpu_wr_en;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [31:0] cpu_rdata, s_rdata;
    logic        cpu_ready, s_ready;
    logic        mem_req, s_req;
    logic        mem_we, s_we;
    logic [31:0] mem_addr, s_addr;
    logic [31:0] mem_wdata, s_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_count, miss_count;
    logic [1:0]  s_hits, s_misses;

    always #5 clk = ~clk;

    dcache_2way_ctrl dut (
        .clk(clk), .rst(rst), .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
    );

    dcache_2way_ctrl #(.STAT_W(2)) dut_s (
        .clk(clk), .rst(rst), .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(s_rdata),
        .cpu_ready(s_ready), .mem_req(s_req), .mem_we(s_we),
        .mem_addr(s_addr), .mem_wdata(s_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .hit_count(s_hits), .miss_count(s_misses)
    );

    int errors = 0;
    int checks = 0;

    // Backing memory and per-set recency list (mru first, then lru line).
    bit [31:0] mem [bit [31:0]];
    bit [31:0] mru_line [64];
    bit [31:0] lru_line [64];
    int        lines_in [64];
    int unsigned exp_hits, exp_misses;
    int        last_low;
    logic      first_ready;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic bit [31:0] memval(input bit [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic int set_of(input bit [31:0] a);
        return int'((a / 8) % 64);
    endfunction

    function automatic bit cached(input bit [31:0] line);
        int s = set_of(line);
        return (lines_in[s] >= 1 && mru_line[s] == line) || (lines_in[s] == 2 && lru_line[s] == line);
    endfunction

    task automatic model_touch(input bit [31:0] line);
        int s = set_of(line);
        if (lines_in[s] == 2 && lru_line[s] == line) begin
            lru_line[s] = mru_line[s];
            mru_line[s] = line;
        end
    endtask

    task automatic model_fill(input bit [31:0] line);
        int s = set_of(line);
        if (lines_in[s] == 0) begin
            mru_line[s] = line;
            lines_in[s] = 1;
        end else begin
            lru_line[s] = mru_line[s];
            mru_line[s] = line;
            lines_in[s] = 2;
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 64; s++) lines_in[s] = 0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic check_counters();
        chk("hit_count",    hit_count,  (exp_hits   > 65535) ? 65535 : exp_hits);
        chk("miss_count",   miss_count, (exp_misses > 65535) ? 65535 : exp_misses);
        chk("hit_count_s",  s_hits,     (exp_hits   > 3) ? 3 : exp_hits);
        chk("miss_count_s", s_misses,   (exp_misses > 3) ? 3 : exp_misses);
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_read(input bit [31:0] a, input int lat);
        bit [31:0] line = a & ~32'h7;
        bit [31:0] word = a & ~32'h3;
        bit        h    = cached(line);
        cpu_rd_en = 1'b1; cpu_wr_en = 1'b0; cpu_addr = a; mem_ack = 1'b0;
        mem_rdata = {$urandom, $urandom};
        #1;
        first_ready = cpu_ready;
        if (h) begin
            chk("hit_ready", cpu_ready, 1);
            chk("hit_rdata", cpu_rdata, memval(word));
            chk("hit_memreq", mem_req, 0);
            @(posedge clk); #1;
            exp_hits++;
            model_touch(line);
        end else begin
            last_low = 1;
            chk("miss_ready", cpu_ready, 0);
            chk("miss_memreq_idle", mem_req, 0);
            @(posedge clk); #1;
            exp_misses++;
            repeat (lat) begin
                chk("fill_req", mem_req, 1);
                chk("fill_we", mem_we, 0);
                chk("fill_addr", mem_addr, line);
                chk("fill_ready", cpu_ready, 0);
                last_low++;
                mem_rdata = {$urandom, $urandom};
                @(posedge clk); #1;
            end
            mem_ack = 1'b1;
            mem_rdata = {memval(line + 4), memval(line)};
            #1;
            chk("ack_ready", cpu_ready, 1);
            chk("ack_rdata", cpu_rdata, memval(word));
            chk("ack_addr", mem_addr, line);
            @(posedge clk); #1;
            mem_ack = 1'b0;
            model_fill(line);
        end
        cpu_rd_en = 1'b0;
    endtask

    task automatic do_write(input bit [31:0] a, input bit [31:0] d, input int lat, input bit both);
        bit [31:0] line = a & ~32'h7;
        cpu_wr_en = 1'b1; cpu_rd_en = both; cpu_addr = a; cpu_wdata = d; mem_ack = 1'b0;
        #1;
        chk("wr_ready_idle", cpu_ready, 0);
        chk("wr_req_idle", mem_req, 0);
        @(posedge clk); #1;
        repeat (lat) begin
            chk("wr_req", mem_req, 1);
            chk("wr_we", mem_we, 1);
            chk("wr_addr", mem_addr, a);
            chk("wr_wdata", mem_wdata, d);
            chk("wr_ready", cpu_ready, 0);
            @(posedge clk); #1;
        end
        mem_ack = 1'b1;
        #1;
        chk("wr_ack_ready", cpu_ready, 1);
        chk("wr_ack_we", mem_we, 1);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        mem[a & ~32'h3] = d;
        if (cached(line)) model_touch(line);
        cpu_wr_en = 1'b0; cpu_rd_en = 1'b0;
    endtask

    task automatic do_idle(input bit ack);
        cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; mem_ack = ack;
        mem_rdata = {$urandom, $urandom};
        #1;
        chk("idle_ready", cpu_ready, 1);
        chk("idle_req", mem_req, 0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; mem_ack = 1'b0;
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ready", cpu_ready, 1);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_misses", miss_count, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        rst = 1'b0; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; cpu_addr = '0;
        cpu_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        @(posedge clk); #1;
        apply_reset();

        // Cold miss then hit
        mem[32'h100] = 32'hAAAA_AAAA;
        mem[32'h104] = 32'hBBBB_BBBB;
        do_read(32'h104, 2);
        chk("t1_ready_low_cycles", last_low, 3);
        do_read(32'h100, 0);
        chk("t1_hit_same_cycle", first_ready, 1);
        chk("t1_hits", hit_count, 1);
        chk("t1_misses", miss_count, 1);

        // LRU eviction
        do_read(32'h300, 1);
        do_read(32'h100, 0);
        do_read(32'h500, 3);
        do_read(32'h100, 0);
        chk("t2_0x100_hits", first_ready, 1);
        do_read(32'h300, 1);
        chk("t2_0x300_misses", first_ready, 0);
        check_counters();

        // Write-through, write hit and write miss
        do_write(32'h100, 32'h1234_5678, 2, 1'b0);
        do_read(32'h100, 0);
        chk("t3_hit_after_write", first_ready, 1);
        chk("t3_data_after_write", cpu_rdata, 32'h1234_5678);
        do_write(32'h700, 32'h0BAD_F00D, 1, 1'b0);
        do_read(32'h700, 1);
        chk("t3_write_miss_no_alloc", first_ready, 0);

        // Both enables: treated as a write, counters untouched
        check_counters();
        do_write(32'h100, 32'hCAFE_F00D, 1, 1'b1);
        check_counters();

        // Reset in the middle of a fill
        cpu_rd_en = 1'b1; cpu_addr = 32'hB00; #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_req_in_fill", mem_req, 1);
        rst = 1'b0; #1;
        chk("t5_req_async_drop", mem_req, 0);
        chk("t5_ready_in_reset", cpu_ready, 1);
        @(posedge clk); #1;
        rst = 1'b1; cpu_rd_en = 1'b0;
        model_reset();
        do_idle(1'b1);
        check_counters();
        do_read(32'h100, 1);
        chk("t5_miss_after_reset", first_ready, 0);

        // Counter saturation on the 2-bit instance
        repeat (5) do_read(32'h100, 0);
        chk("t6_sat_hits", s_hits, 3);
        chk("t6_wide_hits", hit_count, 5);
        check_counters();

        // Random traffic over 4 sets x 4 tags to force conflicts
        for (int i = 0; i < 400; i++) begin
            int unsigned r   = $urandom_range(0, 99);
            bit [31:0]   a   = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 3) | ($urandom_range(0, 1) << 2);
            int          lat = $urandom_range(0, 3);
            if (r < 55)      do_read(a, lat);
            else if (r < 80) do_write(a, $urandom, lat, 1'b0);
            else if (r < 88) do_write(a, $urandom, lat, 1'b1);
            else             do_idle(1'($urandom_range(0, 1)));
            if (i % 50 == 49) check_counters();
        end
        check_counters();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_2way_ctrl.md
Name: dcache_2way_ctrl

Overview:
- Parametrised 2-way set-associative, write-through, no-write-allocate data cache.
- Sits between the pipeline MEM stage and the backing data memory (SRAM controller).
- Replaces the single-cycle memory path: a multi-cycle backing store is hidden behind `cpu_ready`; the top level ORs `~cpu_ready` into the pipeline freeze.
- Adds LRU replacement and hit/miss statistics counters.

Parameters:
- DATA_W, 32, word width in bits.
- ADDR_W, 32, byte-address width.
- SETS, 64, number of sets; power of 2, at least 2.
- LINE_WORDS, 2, words per line; power of 2, at least 1.
- STAT_W, 16, width of the hit and miss counters.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_rd_en  in  1  load request from the MEM stage.
- cpu_wr_en  in  1  store request from the MEM stage.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data, valid when cpu_ready=1 and cpu_rd_en=1.
- cpu_ready  out  1  request complete / no stall.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  1 = single-word write, 0 = line read.
- mem_addr  out  ADDR_W  line-aligned address for reads; word address for writes.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  LINE_WORDS*DATA_W  line data; word 0 in the LSBs.
- mem_ack  in  1  single-cycle completion pulse.
- hit_count  out  STAT_W  saturating count of read hits.
- miss_count  out  STAT_W  saturating count of read misses.

Behaviour:
- Address split:
  - offset = log2(LINE_WORDS) bits above [1:0].
  - index = log2(SETS) bits above offset.
  - tag = remaining upper bits.
- Per set: valid[1:0], tag[1:0], LINE_WORDS data words per way, and one LRU bit (LRU = way to evict next).
- FSM states: IDLE, FILL, WRITE. All are registered. Outputs are combinational from state and inputs.
- IDLE, no request:
  - cpu_ready=1, mem_req=0.
- IDLE, read hit:
  - cpu_ready=1 in the same cycle (0 stall cycles).
  - cpu_rdata = the hitting way's word.
  - At the edge: LRU set to the other way, hit_count += 1.
- IDLE, read miss:
  - cpu_ready=0; next state FILL.
  - miss_count += 1 at the edge.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = line-aligned cpu_addr, cpu_ready=0 until mem_ack.
  - On mem_ack: cpu_ready=1 and cpu_rdata = selected word of mem_rdata in that cycle.
  - At the edge: line written into the victim way, valid set, tag written, LRU set to the other way, return to IDLE.
  - Victim: an invalid way first (way0 if both invalid), otherwise the LRU way.
- IDLE with cpu_wr_en:
  - cpu_ready=0; next state WRITE.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - On mem_ack: cpu_ready=1. If the address hits a way at that edge, the word in that way is updated and LRU set to the other way.
  - A write miss does not allocate. Return to IDLE.
- cpu_wr_en and cpu_rd_en both high: treated as a write; the read is ignored.
- The requester must hold cpu_addr, cpu_wdata and the enables stable while cpu_ready=0. The cache samples them combinationally in every state.
- mem_req drops the cycle after mem_ack because the state returns to IDLE. Back-to-back misses therefore show at least one mem_req-low cycle between them.
- mem_ack outside FILL/WRITE is ignored.
- Counters saturate at 2^STAT_W-1; they do not wrap.
- Reset (asynchronous, immediate):
  - state=IDLE, all valid and LRU bits=0, counters=0.
  - mem_req, mem_we = 0; mem_addr, mem_wdata = 0; cpu_rdata = 0; cpu_ready=1.
  - Reset during FILL or WRITE aborts the transaction; a late mem_ack is ignored.
- Data arrays are not reset.

Test Plan:
Defaults apply: SETS=64, LINE_WORDS=2, so index=addr[8:3] and tag=addr[31:9].
1. Cold read miss then hit:
   - rd 0x0000_0104; ack after 3 cycles with mem_rdata={0xBBBB_BBBB,0xAAAA_AAAA}.
   - Required: mem_addr=0x0000_0100, cpu_ready low for 3 cycles, rdata=0xBBBB_BBBB on the ack cycle.
   - Then rd 0x0000_0100 → ready the same cycle, rdata=0xAAAA_AAAA; hit_count=1, miss_count=1.
2. LRU eviction:
   - Fill 0x0000_0100 (way0), then 0x0000_0300 (way1, same set), read 0x100 again, then fill 0x0000_0500.
   - Required: way1 (0x300) is evicted; rd 0x100 hits; rd 0x300 misses.
3. Write-through:
   - With 0x100 cached, write 0x100=0x1234_5678.
   - Required: mem_req=1 and mem_we=1 until ack; subsequent rd 0x100 hits with 0x1234_5678.
   - Write 0x0000_0700 (miss) → no allocation; rd 0x700 misses.
4. Simultaneous enables:
   - rd_en=1 and wr_en=1 at 0x100.
   - Required: mem_we=1, and the counters are unchanged.
5. Reset mid-fill:
   - Assert rst=0 two cycles into FILL, release, then pulse mem_ack.
   - Required: mem_req drops asynchronously, state returns to IDLE, the ack is ignored, rd 0x100 misses.
6. Counter saturation:
   - STAT_W=2; perform 5 read hits.
   - Required: hit_count=3.
